// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// Module      : pc_fetch_unit_pkg
// Description : Shared widths, defaults and FSM encodings for the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

   localparam int DEF_XLEN      = 32;
   localparam int DEF_INSTR_NUM = 16;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_PAUSE = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_step_edge_sync.sv
// ============================================================================
// Module      : step_edge_sync
// Description : Two-flop synchronizer followed by a one-clock rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_edge_sync (
   input  logic clk,
   input  logic rstn,
   input  logic in,
   output logic pulse
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign pulse = sync_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : PC owner, step-rate prescaler and run/pause/step/halt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int XLEN      = DEF_XLEN,
   parameter int INSTR_NUM = DEF_INSTR_NUM,
   parameter int ADDR_W    = 4,
   parameter int DIV_FAST  = 25,
   parameter int DIV_SLOW  = 28
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              slow_i,
   input  logic              pause_i,
   input  logic              step_i,
   input  logic              branch_taken_i,
   input  logic              jal_i,
   input  logic              jalr_i,
   input  logic [XLEN-1:0]   imm_i,
   input  logic [XLEN-1:0]   rs1_i,
   output logic [XLEN-1:0]   pc_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic [XLEN-1:0]   link_o,
   output logic              cpu_en_o,
   output logic              halted_o,
   output logic              err_o,
   output logic [1:0]        state_o
);

   localparam logic [XLEN-1:0] END_PC = XLEN'(INSTR_NUM * 4);

   logic [DIV_SLOW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]     pc_q, pc_d;
   state_t              state_q, state_d;
   logic                cpu_en_q, cpu_en_d;
   logic                err_q, err_d;
   logic                halted_q, halted_d;

   logic [XLEN-1:0]     jalr_sum;
   logic [XLEN-1:0]     next_pc;
   logic                tick;
   logic                tgt_end;
   logic                tgt_bad;
   logic                halt_now;
   logic                step_pulse;

   step_edge_sync u_step_sync (
      .clk   (clk),
      .rstn  (rstn),
      .in    (step_i),
      .pulse (step_pulse)
   );

   always_comb begin
      cnt_d    = cnt_q + DIV_SLOW'(1);
      tick     = slow_i ? (&cnt_q) : (&cnt_q[DIV_FAST-1:0]);
      jalr_sum = rs1_i + imm_i;

      if (jalr_i) begin
         next_pc = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (jal_i || branch_taken_i) begin
         next_pc = pc_q + imm_i;
      end else begin
         next_pc = pc_q + XLEN'(4);
      end

      tgt_end = (next_pc == END_PC);
      tgt_bad = (next_pc[1:0] != 2'b00) || (next_pc > END_PC);

      pc_d     = pc_q;
      state_d  = state_q;
      err_d    = err_q;
      cpu_en_d = 1'b0;
      halt_now = 1'b0;

      if (state_q != ST_HALT) begin
         // The commit cycle is the one where cpu_en_q is high; its end edge moves the PC.
         if (cpu_en_q) begin
            if (tgt_end) begin
               pc_d     = next_pc;
               halt_now = 1'b1;
            end else if (tgt_bad) begin
               err_d    = 1'b1;
               halt_now = 1'b1;
            end else begin
               pc_d = next_pc;
            end
         end

         if (halt_now) begin
            state_d = ST_HALT;
         end else if (state_q == ST_RUN) begin
            if (tick) begin
               if (pause_i) begin
                  state_d = ST_PAUSE;
               end else begin
                  cpu_en_d = 1'b1;
               end
            end
         end else begin
            if (step_pulse) begin
               cpu_en_d = 1'b1;
            end
            if (!pause_i) begin
               state_d = ST_RUN;
            end
         end
      end

      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q    <= '0;
         pc_q     <= '0;
         state_q  <= ST_RUN;
         cpu_en_q <= 1'b0;
         err_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         pc_q     <= pc_d;
         state_q  <= state_d;
         cpu_en_q <= cpu_en_d;
         err_q    <= err_d;
         halted_q <= halted_d;
      end
   end

   assign pc_o       = pc_q;
   assign rom_addr_o = pc_q[ADDR_W+1:2];
   assign link_o     = pc_q + XLEN'(4);
   assign cpu_en_o   = cpu_en_q;
   assign halted_o   = halted_q;
   assign err_o      = err_q;
   assign state_o    = state_q;

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch-side sequencer for the single-cycle RV32 core. Owns the PC, the CPU step-rate prescaler, the run/pause/single-step control and end-of-program halt.
- Drives the instruction-ROM word address and a one-cycle commit enable. RF/DM writes are gated by the commit enable, so the core runs on the board clock instead of a divided clock.
- Consumes branch/jump decisions and immediates from Ctrl/immGen/ALU. Supplies the link value to the write-back mux.

Parameters:
- XLEN, 32, datapath width
- INSTR_NUM, 16, program length in words; PC == INSTR_NUM*4 means end
- ADDR_W, 4, ROM word-address width; must satisfy 2^ADDR_W >= INSTR_NUM
- DIV_FAST, 25, fast step period = 2^DIV_FAST clk
- DIV_SLOW, 28, slow step period = 2^DIV_SLOW clk; DIV_SLOW > DIV_FAST

Ports:
- clk  in  1  board clock
- rstn  in  1  asynchronous active-low reset
- slow_i  in  1  1 = slow step rate
- pause_i  in  1  1 = pause auto-run
- step_i  in  1  asynchronous single-step button, level
- branch_taken_i  in  1  conditional branch taken (pcSrc & zero)
- jal_i  in  1  current instruction is JAL
- jalr_i  in  1  current instruction is JALR
- imm_i  in  XLEN  sign-extended immediate, byte offset
- rs1_i  in  XLEN  rs1 value, for JALR
- pc_o  out  XLEN  byte PC of current instruction
- rom_addr_o  out  ADDR_W  pc_o[ADDR_W+1:2]
- link_o  out  XLEN  pc_o + 4
- cpu_en_o  out  1  commit pulse, one clk wide
- halted_o  out  1  sticky halt
- err_o  out  1  sticky illegal-target flag
- state_o  out  2  FSM state, for the display mux

Behaviour:
- Reset (async, any time, including mid-step): pc=0, state=RUN, prescaler=0, cpu_en=0, halted=0, err=0, sync/edge flops=0.
- Prescaler: free-running counter, DIV_SLOW bits. tick = slow_i ? (counter all-ones) : (low DIV_FAST bits all-ones). slow_i is sampled combinationally; a rate change takes effect at the next matching tick.
- next_pc is combinational:
  - jalr_i: (rs1_i+imm_i) & ~1
  - else jal_i | branch_taken_i: pc+imm_i
  - else pc+4
  - All arithmetic is modulo 2^XLEN. Priority: jalr > jal/branch > sequential.
- Commit cycle:
  - cpu_en_o=1 for exactly that clk. pc updates on the same edge that ends it.
  - The current instruction's RF/DM writes use that edge.
- Target check, applied at commit:
  - next_pc == INSTR_NUM*4: pc<=next_pc; go HALT; err stays 0.
  - next_pc[1:0] != 0, or next_pc > INSTR_NUM*4 (unsigned): the instruction still commits. pc holds its value, state goes HALT, err=1.
- FSM (RUN=0, PAUSE=1, HALT=2):
  - RUN: tick & pause_i -> PAUSE, no commit. tick & !pause_i -> commit.
  - PAUSE: step_i passes a 2-flop sync then a rising-edge detect; each edge gives one commit, regardless of tick. When pause_i=0 -> RUN.
  - PAUSE, step edge and pause_i=0 in the same cycle: commit and go to RUN.
  - HALT: absorbing until reset. cpu_en=0; pc, err and halted are frozen.
  - A step edge in the same cycle as the RUN->PAUSE transition is ignored.
- halted_o = (state==HALT). state_o = state encoding.
- Outputs are registered, except rom_addr_o and link_o, which are derived combinationally from the pc register.

Decomposition:
- Shared package: state encodings, XLEN, INSTR_NUM default.
- One sub-module: step_edge_sync (2-flop synchronizer plus rising-edge pulse; ports clk, rstn, in, pulse).

Test Plan (DIV_FAST=2, DIV_SLOW=4, INSTR_NUM=8):
- Reset, then run with no jumps -> cpu_en every 4 clk. pc goes 0,4,…,28, then 32 with halted=1, err=0. Exactly 8 pulses, none afterwards.
- slow_i=1 from reset -> commits every 16 clk. Toggle slow_i to 0 mid-run -> next commit is at the next 4-clk boundary.
- At pc=12 with jal_i=1, imm=-8 -> pc=4, link_o=16 during the commit. At pc=4 with jalr_i=1, rs1=0x10, imm=5 -> pc=0x14.
- jalr_i=1 with rs1=0x11, imm=2 (target 0x12): one commit, pc unchanged, err=1, halted=1. Separately, branch_taken_i with imm=+64 gives the same result.
- pause_i=1 -> no commits for 40 clk. step_i held for 20 clk -> exactly one commit and pc+4. Second press -> one more commit. pause_i=0 -> auto-run resumes.
- Assert rstn low mid-pause at pc=20 -> all outputs return to their reset values immediately, state=RUN, and the next commit occurs at pc=0.
